// File: rtl/cabac_ram_arb_ctrl_pkg.sv
// Shared constants for the CABAC context SRAM arbiter: default geometry and FSM encoding.
package cabac_ram_arb_ctrl_pkg;

  localparam int CABAC_RAM_WW = 16;
  localparam int CABAC_RAM_AW = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_INIT = 1'b1;

endpackage

// File: rtl/cabac_ram_arb_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module cabac_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // Side that wins a tie next: 0 = A, 1 = B. Flipped away from whoever was just served.
  logic prio_q, prio_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/cabac_ram_arb_ctrl.sv
// Arbitrates one single-port CABAC context SRAM between requesters A and B,
// and runs the slice-start sequencer that clears every word to INIT_DATA.
module cabac_ram_arb_ctrl
  import cabac_ram_arb_ctrl_pkg::*;
#(
  parameter int                    WORD_WIDTH = CABAC_RAM_WW,
  parameter int                    ADDR_WIDTH = CABAC_RAM_AW,
  parameter logic [WORD_WIDTH-1:0] INIT_DATA  = '0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  init_start_i,
  output logic                  init_busy_o,
  output logic                  init_done_o,

  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [WORD_WIDTH-1:0] a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,

  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [WORD_WIDTH-1:0] b_wdata_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,

  output logic [WORD_WIDTH-1:0] rdata_o,

  output logic                  ram_cen_o,
  output logic                  ram_oen_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_data_o,
  input  logic [WORD_WIDTH-1:0] ram_data_i
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  a_rvalid_q, b_rvalid_q;
  logic                  arb_en;
  logic [1:0]            arb_gnt;

  // Grants only in IDLE, and a same-cycle init_start_i takes the port away from the requesters.
  assign arb_en = (state_q == ST_IDLE) && !init_start_i && !rst;

  cabac_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({b_req_i, a_req_i} & {2{arb_en}}),
    .advance_i (arb_en),
    .gnt_o     (arb_gnt)
  );

  assign a_gnt_o = arb_gnt[0];
  assign b_gnt_o = arb_gnt[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (init_start_i) begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      a_rvalid_q <= a_gnt_o && !a_we_i;
      b_rvalid_q <= b_gnt_o && !b_we_i;
    end
  end

  // SRAM port mux; reset forces the port quiet even if the FSM was mid-init.
  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        ram_cen_o  = 1'b0;
        ram_wen_o  = 1'b0;
        ram_addr_o = cnt_q;
        ram_data_o = INIT_DATA;
      end else if (a_gnt_o) begin
        ram_cen_o  = 1'b0;
        ram_wen_o  = !a_we_i;
        ram_addr_o = a_addr_i;
        ram_data_o = a_wdata_i;
      end else if (b_gnt_o) begin
        ram_cen_o  = 1'b0;
        ram_wen_o  = !b_we_i;
        ram_addr_o = b_addr_i;
        ram_data_o = b_wdata_i;
      end
    end
  end

  assign ram_oen_o   = 1'b0;
  assign init_busy_o = (state_q == ST_INIT);
  assign init_done_o = done_q;
  assign a_rvalid_o  = a_rvalid_q;
  assign b_rvalid_o  = b_rvalid_q;
  assign rdata_o     = ram_data_i;

endmodule

// File: tb/tb_cabac_ram_arb_ctrl.sv
// Self-checking bench for cabac_ram_arb_ctrl: behavioural SRAM, reference memory and read scoreboard.
module tb_cabac_ram_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_start_i;
  logic        init_busy_o, init_done_o;
  logic        a_req_i, a_we_i, a_gnt_o, a_rvalid_o;
  logic [7:0]  a_addr_i;
  logic [15:0] a_wdata_i;
  logic        b_req_i, b_we_i, b_gnt_o, b_rvalid_o;
  logic [7:0]  b_addr_i;
  logic [15:0] b_wdata_i;
  logic [15:0] rdata_o;
  logic        ram_cen_o, ram_oen_o, ram_wen_o;
  logic [7:0]  ram_addr_o;
  logic [15:0] ram_data_o, ram_data_i;

  always #5 clk = ~clk;

  cabac_ram_arb_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .init_start_i (init_start_i),
    .init_busy_o  (init_busy_o),
    .init_done_o  (init_done_o),
    .a_req_i      (a_req_i),
    .a_we_i       (a_we_i),
    .a_addr_i     (a_addr_i),
    .a_wdata_i    (a_wdata_i),
    .a_gnt_o      (a_gnt_o),
    .a_rvalid_o   (a_rvalid_o),
    .b_req_i      (b_req_i),
    .b_we_i       (b_we_i),
    .b_addr_i     (b_addr_i),
    .b_wdata_i    (b_wdata_i),
    .b_gnt_o      (b_gnt_o),
    .b_rvalid_o   (b_rvalid_o),
    .rdata_o      (rdata_o),
    .ram_cen_o    (ram_cen_o),
    .ram_oen_o    (ram_oen_o),
    .ram_wen_o    (ram_wen_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o),
    .ram_data_i   (ram_data_i)
  );

  // Behavioural single-port SRAM, read data one cycle after the access.
  logic [15:0] sram [256];
  logic [15:0] sram_q;
  always @(posedge clk) begin
    if (!ram_cen_o) begin
      if (!ram_wen_o) sram[ram_addr_o] <= ram_data_o;
      else            sram_q <= sram[ram_addr_o];
    end
  end
  assign ram_data_i = sram_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          side;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [256];
  logic [7:0]  exp_init;
  int          busy_cycles = 0;
  int          done_count  = 0;
  bit          busy_prev   = 1'b0;

  // Monitor: every grant/init write is checked against the bench's own view,
  // reads push the expected word, rvalids pop and compare.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (a_rvalid_o || b_rvalid_o) begin
        check("rvalid_both", 32'(a_rvalid_o && b_rvalid_o), 32'(0));
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 32'(exp_q.size()), 32'(1));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rvalid_side", 32'(b_rvalid_o), 32'(e.side));
          check("rdata", 32'(rdata_o), 32'(e.data));
        end
      end
      if (a_gnt_o || b_gnt_o) begin
        bit          side, we;
        logic [7:0]  addr;
        logic [15:0] wd;
        side = b_gnt_o;
        we   = side ? b_we_i : a_we_i;
        addr = side ? b_addr_i : a_addr_i;
        wd   = side ? b_wdata_i : a_wdata_i;
        check("gnt_onehot", 32'(a_gnt_o && b_gnt_o), 32'(0));
        check("gnt_during_init", 32'(init_busy_o), 32'(0));
        check("gnt_without_req", 32'(side ? b_req_i : a_req_i), 32'(1));
        check("ram_cen_gnt", 32'(ram_cen_o), 32'(0));
        check("ram_wen_gnt", 32'(ram_wen_o), 32'(!we));
        check("ram_addr_gnt", 32'(ram_addr_o), 32'(addr));
        if (we) begin
          check("ram_data_gnt", 32'(ram_data_o), 32'(wd));
          ref_mem[addr] = wd;
        end else begin
          exp_q.push_back('{side: side, data: ref_mem[addr]});
        end
      end else if (init_busy_o) begin
        if (!busy_prev) begin
          busy_cycles = 0;
          exp_init    = 8'd0;
        end
        busy_cycles++;
        check("init_cen", 32'(ram_cen_o), 32'(0));
        check("init_wen", 32'(ram_wen_o), 32'(0));
        check("init_addr", 32'(ram_addr_o), 32'(exp_init));
        check("init_data", 32'(ram_data_o), 32'(16'h0000));
        ref_mem[exp_init] = 16'h0000;
        exp_init = exp_init + 8'd1;
      end else begin
        check("idle_cen", 32'(ram_cen_o), 32'(1));
        check("idle_wen", 32'(ram_wen_o), 32'(1));
      end
      check("oen_tied", 32'(ram_oen_o), 32'(0));
      if (init_done_o) done_count++;
    end
    busy_prev = init_busy_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    init_start_i = 1'b1;
    tick();
    init_start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!init_done_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("init_done_timeout", 32'(n < 400), 32'(1));
    @(negedge clk);
  endtask

  // Hold a request until granted, then drop it right after the granting edge.
  task automatic do_req(input bit side, input bit we, input logic [7:0] addr, input logic [15:0] wd,
                        output bit busy_at_gnt, output bit done_at_gnt);
    int n = 0;
    if (side) begin
      b_req_i = 1'b1; b_we_i = we; b_addr_i = addr; b_wdata_i = wd;
    end else begin
      a_req_i = 1'b1; a_we_i = we; a_addr_i = addr; a_wdata_i = wd;
    end
    @(negedge clk);
    while (!(side ? b_gnt_o : a_gnt_o) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("gnt_timeout", 32'(n < 400), 32'(1));
    busy_at_gnt = init_busy_o;
    done_at_gnt = init_done_o;
    tick();
    if (side) b_req_i = 1'b0;
    else      a_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bz, dn;
    int d0, n;
    rst = 1'b1; init_start_i = 1'b0;
    a_req_i = 1'b0; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0;
    b_req_i = 1'b0; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0;

    // 1. reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_cen", 32'(ram_cen_o), 32'(1));
    check("rst_wen", 32'(ram_wen_o), 32'(1));
    check("rst_oen", 32'(ram_oen_o), 32'(0));
    check("rst_addr", 32'(ram_addr_o), 32'(0));
    check("rst_data", 32'(ram_data_o), 32'(0));
    check("rst_gnt", 32'({a_gnt_o, b_gnt_o}), 32'(0));
    check("rst_rvalid", 32'({a_rvalid_o, b_rvalid_o}), 32'(0));
    check("rst_busy", 32'(init_busy_o), 32'(0));
    check("rst_done", 32'(init_done_o), 32'(0));
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // 2. full init, with a second start mid-sequence that must be ignored
    pulse_init();
    repeat (50) tick();
    pulse_init();
    wait_done();
    check("init_busy_cycles", 32'(busy_cycles), 32'(256));
    check("init_done_count", 32'(done_count), 32'(1));

    // 3. write/read traffic, back-to-back reads, same-address write then read
    do_req(1'b0, 1'b1, 8'h10, 16'hBEEF, bz, dn);
    do_req(1'b1, 1'b0, 8'h10, 16'h0000, bz, dn);
    @(negedge clk);
    check("b_rvalid_after_gnt", 32'(b_rvalid_o), 32'(1));
    check("b_rdata_beef", 32'(rdata_o), 32'(16'hBEEF));
    tick();
    do_req(1'b0, 1'b1, 8'h20, 16'h1234, bz, dn);
    do_req(1'b0, 1'b0, 8'h10, 16'h0000, bz, dn);
    do_req(1'b0, 1'b0, 8'h20, 16'h0000, bz, dn);
    do_req(1'b0, 1'b1, 8'h20, 16'h5A5A, bz, dn);
    do_req(1'b1, 1'b0, 8'h20, 16'h0000, bz, dn);
    repeat (3) tick();

    // 4. both requesting: strict alternation starting with A
    a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = 8'h10;
    b_req_i = 1'b1; b_we_i = 1'b0; b_addr_i = 8'h20;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_a", 32'(a_gnt_o), 32'((i % 2) == 0));
      check("rr_b", 32'(b_gnt_o), 32'((i % 2) == 1));
    end
    tick();
    a_req_i = 1'b0; b_req_i = 1'b0;
    repeat (3) tick();

    // 5. init_start with a request in the same cycle, then the request waits out init
    init_start_i = 1'b1; a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = 8'h10;
    @(negedge clk);
    check("start_blocks_gnt", 32'(a_gnt_o), 32'(0));
    tick();
    init_start_i = 1'b0;
    d0 = done_count;
    do_req(1'b0, 1'b0, 8'h10, 16'h0000, bz, dn);
    check("init_req_busy_at_gnt", 32'(bz), 32'(0));
    check("init_req_first_idle", 32'(dn), 32'(1));
    repeat (3) tick();
    check("init2_done_count", 32'(done_count - d0), 32'(1));

    // 6. reset at init address 100, no done, then a clean restart from 0
    pulse_init();
    n = 0;
    @(negedge clk);
    while (!(init_busy_o && ram_addr_o == 8'd100) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr_100", 32'(n < 400), 32'(1));
    d0 = done_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_init_busy", 32'(init_busy_o), 32'(0));
    check("rst_mid_init_cen", 32'(ram_cen_o), 32'(1));
    repeat (300) tick();
    check("rst_mid_init_no_done", 32'(done_count - d0), 32'(0));
    pulse_init();
    wait_done();
    check("restart_busy_cycles", 32'(busy_cycles), 32'(256));
    check("restart_done_count", 32'(done_count - d0), 32'(1));

    // reset while a read is in flight drops its rvalid
    a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = 8'h10;
    @(negedge clk);
    check("inflight_gnt", 32'(a_gnt_o), 32'(1));
    rst = 1'b1;
    #6;
    a_req_i = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_drops_rvalid", 32'(a_rvalid_o), 32'(0));

    repeat (4) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
